rx_pkt_fifo: RTL and testbench
==============================

Name: rx_pkt_fifo

Overview:
- Single-clock, parametrised receive FIFO for the USB RX path. Adds packet-level commit/discard, so a packet that fails CRC or PID checks is rolled back before the bus can see it.
- The write side is driven by the USB RX packet logic. The read side is a register-mapped bus slave (data pop, status, occupancy, control, threshold).
- Replaces the dual-clock RX FIFO plus bus-interface pair wherever bus and USB logic share one clock.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the bus data ports; legal range 8..16.
- FIFO_DEPTH, 64, number of entries; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 6, pointer index width; legal range 2..15.

Ports:
- busClk  in  1  clock, rising edge.
- rstSyncToBusClk  in  1  synchronous, active-high reset.
- fifoWEn  in  1  write fifoDataIn into the current (uncommitted) packet.
- fifoDataIn  in  DATA_WIDTH  write data.
- pktCommit  in  1  make all words written since the last commit/discard readable.
- pktDiscard  in  1  drop all words written since the last commit/discard.
- fifoFull  out  1  no free entry, counting uncommitted words.
- fifoAlmostFull  out  1  committed count >= threshold register.
- busAddress  in  3  register select.
- busWriteEn  in  1  1 = bus write, 0 = bus read.
- busStrobe_i  in  1  one access per cycle while high.
- busFifoSelect  in  1  access targets this block.
- busDataIn  in  DATA_WIDTH  bus write data.
- busDataOut  out  DATA_WIDTH  registered bus read data.

Behaviour:
- Pointers: rdPtr, cmtPtr and wrPtr, each ADDR_WIDTH+1 bits, wrapping modulo 2*FIFO_DEPTH.
  - used = wrPtr - rdPtr.
  - committed = cmtPtr - rdPtr.
  - empty = (committed == 0).
  - fifoFull = (used == FIFO_DEPTH).
- Reset:
  - All pointers 0, busDataOut 0, fifoFull 0, fifoAlmostFull 0.
  - Overflow sticky 0, pktBad 0, threshold = FIFO_DEPTH-1.
- Access qualifier: acc = busStrobe_i & busFifoSelect. Reads return data in busDataOut on the cycle after acc (1-cycle latency). busDataOut holds its value otherwise.
- Register map (busAddress):
  - 0 read: pop one word. Data = mem[rdPtr]; rdPtr increments. If empty, returns 0 and rdPtr is unchanged. Write is ignored.
  - 1 read: status. bit0 empty, bit1 fifoFull, bit2 fifoAlmostFull, bit3 overflow sticky. Upper bits 0.
  - 2 read: committed count[15:8]. 3 read: committed count[7:0]. Zero-extended; bits above DATA_WIDTH are dropped.
  - 4 write: control. bit0 forceEmpty, bit1 clearOverflow. Read returns 0.
  - 5 read/write: threshold, ADDR_WIDTH+1 bits, zero-extended on read.
  - 6, 7: read 0, writes ignored.
- Write side:
  - fifoWEn & !fifoFull: mem[wrPtr] <= fifoDataIn; wrPtr increments.
  - fifoWEn & fifoFull: word dropped; pktBad <= 1.
- Packet end:
  - pktDiscard: wrPtr <= cmtPtr; pktBad <= 0.
  - pktCommit & !pktBad: cmtPtr <= wrPtr, including a word written in the same cycle.
  - pktCommit & pktBad: treated as a discard; overflow sticky <= 1.
  - pktCommit & pktDiscard together: discard wins.
- Pop same cycle as commit: both apply. committed reflects both on the next cycle.
- forceEmpty:
  - rdPtr, cmtPtr and wrPtr <= 0; pktBad <= 0; overflow <= 0.
  - Takes priority over any write, commit or pop in the same cycle.
- clearOverflow: overflow <= 0. A set event in the same cycle wins.
- fifoAlmostFull is registered from the next-state committed count vs threshold. Threshold 0 makes it always 1 after the first cycle.
- Flags are registered; fifoFull and status reflect the state after the updating edge.
- Reset mid-packet discards uncommitted and committed data alike.

Test Plan:
- Reset, then write 4 words 0x11..0x14 with no commit -> status bit0 = 1, count = 0. Pulse pktCommit -> count = 4. Four pops return 0x11..0x14 one cycle after each strobe, then empty = 1.
- Write 3 words, pktDiscard, then write 0xA5 and commit in the same cycle -> count = 1 and the pop returns 0xA5.
- Fill 64 words, commit, then one more fifoWEn -> fifoFull = 1, word dropped. The next pktCommit leaves count = 64 and sets overflow bit3 = 1. clearOverflow -> bit3 = 0.
- Wrap: repeat 3x (write and commit 40, pop 40) with an incrementing pattern -> data matches across the pointer wrap, fifoFull never asserts, and the final count is 0.
- Threshold = 8: commit 7 words -> almostFull 0; commit 1 more -> almostFull 1; pop 1 -> 0.
- With 10 committed and 3 uncommitted words, write control forceEmpty in the same cycle as fifoWEn and pktCommit -> count 0, empty 1, and subsequent pops return 0.

Source files
------------

// File: rtl/rx_pkt_fifo.sv
// Single-clock USB RX FIFO with packet-level commit/discard and a small
// register-mapped bus slave for popping data, status, occupancy and control.
module rx_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  busClk,
    input  logic                  rstSyncToBusClk,
    input  logic                  fifoWEn,
    input  logic [DATA_WIDTH-1:0] fifoDataIn,
    input  logic                  pktCommit,
    input  logic                  pktDiscard,
    output logic                  fifoFull,
    output logic                  fifoAlmostFull,
    input  logic [2:0]            busAddress,
    input  logic                  busWriteEn,
    input  logic                  busStrobe_i,
    input  logic                  busFifoSelect,
    input  logic [DATA_WIDTH-1:0] busDataIn,
    output logic [DATA_WIDTH-1:0] busDataOut
);

    localparam int               PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_cmtPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_threshold;
    logic                  r_pktBad;
    logic                  r_overflow;
    logic                  r_full;
    logic                  r_almostFull;
    logic [DATA_WIDTH-1:0] r_busDataOut;

    logic                  w_acc;
    logic                  w_busRead;
    logic                  w_busWrite;
    logic                  w_forceEmpty;
    logic                  w_clearOverflow;
    logic                  w_thresholdWrite;
    logic [PTR_W-1:0]      w_committed;
    logic                  w_empty;
    logic                  w_wrAccept;
    logic                  w_drop;
    logic                  w_pop;
    logic [15:0]           w_count16;
    logic [DATA_WIDTH-1:0] w_readData;
    logic [PTR_W-1:0]      w_wrAfter;
    logic [PTR_W-1:0]      w_rdPtrNext;
    logic [PTR_W-1:0]      w_cmtPtrNext;
    logic [PTR_W-1:0]      w_wrPtrNext;
    logic [PTR_W-1:0]      w_thresholdNext;
    logic                  w_pktBadNext;
    logic                  w_overflowNext;
    logic [PTR_W-1:0]      w_committedNext;
    logic [PTR_W-1:0]      w_usedNext;

    assign w_acc            = busStrobe_i & busFifoSelect;
    assign w_busRead        = w_acc & ~busWriteEn;
    assign w_busWrite       = w_acc & busWriteEn;
    assign w_forceEmpty     = w_busWrite & (busAddress == 3'd4) & busDataIn[0];
    assign w_clearOverflow  = w_busWrite & (busAddress == 3'd4) & busDataIn[1];
    assign w_thresholdWrite = w_busWrite & (busAddress == 3'd5);

    assign w_committed = r_cmtPtr - r_rdPtr;
    assign w_empty     = (w_committed == '0);
    assign w_wrAccept  = fifoWEn & ~r_full;
    assign w_drop      = fifoWEn & r_full;
    assign w_pop       = w_busRead & (busAddress == 3'd0) & ~w_empty;
    assign w_count16   = 16'(w_committed);

    always_comb begin
        w_readData = '0;
        case (busAddress)
            3'd0:    w_readData = w_empty ? '0 : r_mem[r_rdPtr[ADDR_WIDTH-1:0]];
            3'd1:    w_readData = DATA_WIDTH'({r_overflow, r_almostFull, r_full, w_empty});
            3'd2:    w_readData = DATA_WIDTH'(w_count16[15:8]);
            3'd3:    w_readData = DATA_WIDTH'(w_count16[7:0]);
            3'd5:    w_readData = DATA_WIDTH'(r_threshold);
            default: w_readData = '0;
        endcase
    end

    // A word dropped in the same cycle as a commit still spoils that packet.
    always_comb begin
        w_wrAfter      = r_wrPtr + (w_wrAccept ? PTR_ONE : '0);
        w_rdPtrNext    = r_rdPtr;
        w_cmtPtrNext   = r_cmtPtr;
        w_wrPtrNext    = r_wrPtr;
        w_pktBadNext   = r_pktBad;
        w_overflowNext = r_overflow;
        if (w_forceEmpty) begin
            w_rdPtrNext    = '0;
            w_cmtPtrNext   = '0;
            w_wrPtrNext    = '0;
            w_pktBadNext   = 1'b0;
            w_overflowNext = 1'b0;
        end else begin
            w_rdPtrNext  = r_rdPtr + (w_pop ? PTR_ONE : '0);
            w_wrPtrNext  = w_wrAfter;
            w_pktBadNext = r_pktBad | w_drop;
            if (w_clearOverflow) begin
                w_overflowNext = 1'b0;
            end
            if (pktDiscard) begin
                w_wrPtrNext  = r_cmtPtr;
                w_pktBadNext = 1'b0;
            end else if (pktCommit) begin
                if (r_pktBad | w_drop) begin
                    w_wrPtrNext    = r_cmtPtr;
                    w_pktBadNext   = 1'b0;
                    w_overflowNext = 1'b1;
                end else begin
                    w_cmtPtrNext = w_wrAfter;
                end
            end
        end
    end

    assign w_thresholdNext = w_thresholdWrite ? PTR_W'(busDataIn) : r_threshold;
    assign w_committedNext = w_cmtPtrNext - w_rdPtrNext;
    assign w_usedNext      = w_wrPtrNext - w_rdPtrNext;

    always_ff @(posedge busClk) begin
        if (w_wrAccept && !w_forceEmpty) begin
            r_mem[r_wrPtr[ADDR_WIDTH-1:0]] <= fifoDataIn;
        end
    end

    always_ff @(posedge busClk) begin
        if (rstSyncToBusClk) begin
            r_rdPtr      <= '0;
            r_cmtPtr     <= '0;
            r_wrPtr      <= '0;
            r_pktBad     <= 1'b0;
            r_overflow   <= 1'b0;
            r_threshold  <= PTR_W'(FIFO_DEPTH - 1);
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
            r_busDataOut <= '0;
        end else begin
            r_rdPtr      <= w_rdPtrNext;
            r_cmtPtr     <= w_cmtPtrNext;
            r_wrPtr      <= w_wrPtrNext;
            r_pktBad     <= w_pktBadNext;
            r_overflow   <= w_overflowNext;
            r_threshold  <= w_thresholdNext;
            r_full       <= (w_usedNext == PTR_DEPTH);
            r_almostFull <= (w_committedNext >= w_thresholdNext);
            if (w_busRead) begin
                r_busDataOut <= w_readData;
            end
        end
    end

    assign fifoFull       = r_full;
    assign fifoAlmostFull = r_almostFull;
    assign busDataOut     = r_busDataOut;

endmodule

// File: tb/tb_rx_pkt_fifo.sv
// Bench for rx_pkt_fifo: directed scenarios plus a random run, all checked
// against a packet-level queue model of the FIFO.
module tb_rx_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          busClk = 1'b0;
    logic          rstSyncToBusClk;
    logic          fifoWEn;
    logic [DW-1:0] fifoDataIn;
    logic          pktCommit;
    logic          pktDiscard;
    logic          fifoFull;
    logic          fifoAlmostFull;
    logic [2:0]    busAddress;
    logic          busWriteEn;
    logic          busStrobe_i;
    logic          busFifoSelect;
    logic [DW-1:0] busDataIn;
    logic [DW-1:0] busDataOut;

    int checks = 0;
    int errors = 0;

    // Model: committed packets, the packet being built, and sticky flags.
    logic [7:0] cQ[$];
    logic [7:0] pQ[$];
    bit         mBad;
    bit         mOvf;
    int         mThr;
    logic [7:0] heldOut;

    always #5 busClk = ~busClk;

    rx_pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .busClk(busClk),
        .rstSyncToBusClk(rstSyncToBusClk),
        .fifoWEn(fifoWEn),
        .fifoDataIn(fifoDataIn),
        .pktCommit(pktCommit),
        .pktDiscard(pktDiscard),
        .fifoFull(fifoFull),
        .fifoAlmostFull(fifoAlmostFull),
        .busAddress(busAddress),
        .busWriteEn(busWriteEn),
        .busStrobe_i(busStrobe_i),
        .busFifoSelect(busFifoSelect),
        .busDataIn(busDataIn),
        .busDataOut(busDataOut)
    );

    function automatic int mUsed();
        return cQ.size() + pQ.size();
    endfunction

    function automatic bit expFull();
        return mUsed() == DEPTH;
    endfunction

    function automatic bit expAlmostFull();
        return cQ.size() >= mThr;
    endfunction

    task automatic modelReset();
        cQ.delete();
        pQ.delete();
        mBad    = 1'b0;
        mOvf    = 1'b0;
        mThr    = DEPTH - 1;
        heldOut = 8'h00;
    endtask

    // Drives one clock of stimulus, advances the model, samples #1 after the edge.
    task automatic doCycle(input bit we, input logic [7:0] d, input bit cm, input bit dc,
                           input bit acc, input bit bwr, input logic [2:0] addr,
                           input logic [7:0] bdata, output logic [7:0] rdExp, output bit rdValid);
        int used0;
        bit drop;
        bit setOvf;
        used0   = mUsed();
        drop    = 1'b0;
        setOvf  = 1'b0;
        rdValid = acc && !bwr;
        rdExp   = 8'h00;
        if (rdValid) begin
            case (addr)
                3'd0: if (cQ.size() > 0) rdExp = cQ[0];
                3'd1: rdExp = {4'b0000, mOvf, (cQ.size() >= mThr), (used0 == DEPTH), (cQ.size() == 0)};
                3'd2: rdExp = 8'((cQ.size() >> 8) & 255);
                3'd3: rdExp = 8'(cQ.size() & 255);
                3'd5: rdExp = 8'(mThr);
                default: rdExp = 8'h00;
            endcase
        end
        if (acc && bwr && addr == 3'd4 && bdata[0]) begin
            cQ.delete();
            pQ.delete();
            mBad = 1'b0;
            mOvf = 1'b0;
        end else begin
            if (rdValid && addr == 3'd0 && cQ.size() > 0) void'(cQ.pop_front());
            if (we) begin
                if (used0 == DEPTH) drop = 1'b1;
                else pQ.push_back(d);
            end
            if (dc) begin
                pQ.delete();
                mBad = 1'b0;
            end else if (cm) begin
                if (mBad || drop) begin
                    pQ.delete();
                    mBad   = 1'b0;
                    setOvf = 1'b1;
                end else begin
                    foreach (pQ[i]) cQ.push_back(pQ[i]);
                    pQ.delete();
                end
            end else if (drop) begin
                mBad = 1'b1;
            end
            if (setOvf) mOvf = 1'b1;
            else if (acc && bwr && addr == 3'd4 && bdata[1]) mOvf = 1'b0;
        end
        if (acc && bwr && addr == 3'd5) mThr = int'(bdata) & 127;
        if (rdValid) heldOut = rdExp;

        fifoWEn       = we;
        fifoDataIn    = d;
        pktCommit     = cm;
        pktDiscard    = dc;
        busStrobe_i   = acc;
        busFifoSelect = acc;
        busWriteEn    = bwr;
        busAddress    = addr;
        busDataIn     = bdata;
        @(posedge busClk);
        #1;
        fifoWEn       = 1'b0;
        pktCommit     = 1'b0;
        pktDiscard    = 1'b0;
        busStrobe_i   = 1'b0;
        busFifoSelect = 1'b0;
        busWriteEn    = 1'b0;
    endtask

    task automatic wrWord(input logic [7:0] d, input bit cm);
        logic [7:0] e;
        bit v;
        doCycle(1'b1, d, cm, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, e, v);
    endtask

    task automatic pktEnd(input bit cm, input bit dc);
        logic [7:0] e;
        bit v;
        doCycle(1'b0, 8'h00, cm, dc, 1'b0, 1'b0, 3'd0, 8'h00, e, v);
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [7:0] data);
        logic [7:0] e;
        bit v;
        doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, addr, data, e, v);
    endtask

    task automatic busRead(input logic [2:0] addr, output logic [7:0] obs, output logic [7:0] exp);
        bit v;
        doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, addr, 8'h00, exp, v);
        obs = busDataOut;
    endtask

    task automatic applyReset(input int cycles);
        rstSyncToBusClk = 1'b1;
        repeat (cycles) @(posedge busClk);
        #1;
        modelReset();
    endtask

    task automatic test_reset();
        logic [7:0] o;
        logic [7:0] e;
        applyReset(3);
        checks++;
        if (busDataOut !== 8'h00 || fifoFull !== 1'b0 || fifoAlmostFull !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data=%h full=%b af=%b expected 00/0/0",
                     busDataOut, fifoFull, fifoAlmostFull);
        end
        rstSyncToBusClk = 1'b0;
        busRead(3'd1, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected 01", o);
        end
        busRead(3'd5, o, e);
        checks++;
        if (o !== 8'(DEPTH - 1)) begin
            errors++;
            $display("[TB] FAIL reset_threshold: got %h expected %h", o, 8'(DEPTH - 1));
        end
    endtask

    task automatic test_commit_pop();
        logic [7:0] o;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) wrWord(8'(8'h11 + i), 1'b0);
        busRead(3'd1, o, e);
        checks++;
        if (o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uncommitted_empty: got %h expected bit0=1", o);
        end
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL uncommitted_count: got %h expected 00", o);
        end
        pktEnd(1'b1, 1'b0);
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h04) begin
            errors++;
            $display("[TB] FAIL commit_count: got %h expected 04", o);
        end
        for (int i = 0; i < 4; i++) begin
            busRead(3'd0, o, e);
            checks++;
            if (o !== 8'(8'h11 + i) || o !== e) begin
                errors++;
                $display("[TB] FAIL pop_%0d: got %h expected %h", i, o, 8'(8'h11 + i));
            end
        end
        busRead(3'd1, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("[TB] FAIL drained_status: got %h expected 01", o);
        end
    endtask

    task automatic test_discard();
        logic [7:0] o;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) wrWord(8'($urandom), 1'b0);
        pktEnd(1'b0, 1'b1);
        wrWord(8'hA5, 1'b1);
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("[TB] FAIL discard_count: got %h expected 01", o);
        end
        busRead(3'd0, o, e);
        checks++;
        if (o !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL discard_pop: got %h expected a5", o);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] o;
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) wrWord(8'(i * 3 + 1), i == DEPTH - 1);
        checks++;
        if (fifoFull !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_pin: got %b expected 1", fifoFull);
        end
        wrWord(8'hEE, 1'b0);
        checks++;
        if (fifoFull !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_after_drop: got %b expected 1", fifoFull);
        end
        pktEnd(1'b1, 1'b0);
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h40) begin
            errors++;
            $display("[TB] FAIL overflow_count: got %h expected 40", o);
        end
        busRead(3'd1, o, e);
        checks++;
        if (o !== 8'h0E) begin
            errors++;
            $display("[TB] FAIL overflow_status: got %h expected 0e", o);
        end
        busWrite(3'd4, 8'h02);
        busRead(3'd1, o, e);
        checks++;
        if (o !== 8'h06) begin
            errors++;
            $display("[TB] FAIL clear_overflow: got %h expected 06", o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            busRead(3'd0, o, e);
            checks++;
            if (o !== 8'(i * 3 + 1)) begin
                errors++;
                $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, o, 8'(i * 3 + 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] o;
        logic [7:0] e;
        int pat;
        int rd;
        pat = 0;
        rd  = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) begin
                wrWord(8'(pat), i == 39);
                pat++;
                checks++;
                if (fifoFull !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL wrap_full: got %b expected 0", fifoFull);
                end
            end
            for (int i = 0; i < 40; i++) begin
                busRead(3'd0, o, e);
                checks++;
                if (o !== 8'(rd)) begin
                    errors++;
                    $display("[TB] FAIL wrap_data: got %h expected %h", o, 8'(rd));
                end
                rd++;
            end
        end
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL wrap_final_count: got %h expected 00", o);
        end
    endtask

    task automatic test_threshold();
        logic [7:0] o;
        logic [7:0] e;
        busWrite(3'd5, 8'd8);
        for (int i = 0; i < 7; i++) wrWord(8'(i), i == 6);
        checks++;
        if (fifoAlmostFull !== 1'b0) begin
            errors++;
            $display("[TB] FAIL af_at_7: got %b expected 0", fifoAlmostFull);
        end
        wrWord(8'h07, 1'b1);
        checks++;
        if (fifoAlmostFull !== 1'b1) begin
            errors++;
            $display("[TB] FAIL af_at_8: got %b expected 1", fifoAlmostFull);
        end
        busRead(3'd0, o, e);
        checks++;
        if (fifoAlmostFull !== 1'b0) begin
            errors++;
            $display("[TB] FAIL af_after_pop: got %b expected 0", fifoAlmostFull);
        end
        for (int i = 0; i < 7; i++) busRead(3'd0, o, e);
    endtask

    task automatic test_force_empty();
        logic [7:0] o;
        logic [7:0] e;
        bit v;
        for (int i = 0; i < 10; i++) wrWord(8'(8'h30 + i), i == 9);
        for (int i = 0; i < 3; i++) wrWord(8'(8'h50 + i), 1'b0);
        doCycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h01, e, v);
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL force_count: got %h expected 00", o);
        end
        busRead(3'd1, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("[TB] FAIL force_status: got %h expected 01", o);
        end
        for (int i = 0; i < 2; i++) begin
            busRead(3'd0, o, e);
            checks++;
            if (o !== 8'h00) begin
                errors++;
                $display("[TB] FAIL force_pop_%0d: got %h expected 00", i, o);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] o;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) wrWord(8'(8'h60 + i), i == 4);
        for (int i = 0; i < 2; i++) wrWord(8'(8'h70 + i), 1'b0);
        busWrite(3'd5, 8'd0);
        applyReset(1);
        rstSyncToBusClk = 1'b0;
        busRead(3'd3, o, e);
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %h expected 00", o);
        end
        busRead(3'd5, o, e);
        checks++;
        if (o !== 8'(DEPTH - 1)) begin
            errors++;
            $display("[TB] FAIL midreset_threshold: got %h expected %h", o, 8'(DEPTH - 1));
        end
        busRead(3'd0, o, e);
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_pop: got %h expected 00", o);
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        bit v;
        bit we, cm, dc, acc, bwr;
        logic [2:0] addr;
        logic [7:0] bdata;
        int r;
        int wp;
        int pp;
        for (int n = 0; n < 3000; n++) begin
            wp = ((n / 300) % 2 == 0) ? 80 : 35;
            pp = ((n / 300) % 2 == 0) ? 15 : 55;
            we    = ($urandom_range(99) < wp);
            cm    = ($urandom_range(99) < 10);
            dc    = ($urandom_range(99) < 4);
            acc   = 1'b0;
            bwr   = 1'b0;
            addr  = 3'd0;
            bdata = 8'h00;
            r = $urandom_range(99);
            if (r < pp) begin
                acc = 1'b1;
            end else if (r < pp + 10) begin
                acc  = 1'b1;
                addr = 3'($urandom_range(7, 1));
            end else if (r < pp + 11) begin
                acc   = 1'b1;
                bwr   = 1'b1;
                addr  = 3'd4;
                bdata = 8'($urandom_range(3));
            end else if (r < pp + 13) begin
                acc   = 1'b1;
                bwr   = 1'b1;
                addr  = 3'd5;
                bdata = 8'($urandom_range(70));
            end
            doCycle(we, 8'($urandom), cm, dc, acc, bwr, addr, bdata, e, v);
            checks++;
            if (busDataOut !== heldOut) begin
                errors++;
                $display("[TB] FAIL rand_data cycle %0d addr %0d: got %h expected %h",
                         n, addr, busDataOut, heldOut);
            end
            checks++;
            if (fifoFull !== expFull()) begin
                errors++;
                $display("[TB] FAIL rand_full cycle %0d: got %b expected %b", n, fifoFull, expFull());
            end
            checks++;
            if (fifoAlmostFull !== expAlmostFull()) begin
                errors++;
                $display("[TB] FAIL rand_almostfull cycle %0d: got %b expected %b",
                         n, fifoAlmostFull, expAlmostFull());
            end
        end
    endtask

    initial begin
        rstSyncToBusClk = 1'b1;
        fifoWEn         = 1'b0;
        fifoDataIn      = '0;
        pktCommit       = 1'b0;
        pktDiscard      = 1'b0;
        busAddress      = 3'd0;
        busWriteEn      = 1'b0;
        busStrobe_i     = 1'b0;
        busFifoSelect   = 1'b0;
        busDataIn       = '0;
        modelReset();
        test_reset();
        test_commit_pop();
        test_discard();
        test_overflow();
        test_wrap();
        test_threshold();
        test_force_empty();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
